// File: rtl/fg_packet_sink.sv
// Receive-side sink for generated traffic: takes a header plus an AXI-stream payload,
// counts and validates payload bytes, and emits one descriptor per frame with running stats.
module fg_packet_sink #(
    parameter int DEST_WIDTH = 8,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  input_hdr_valid,
    output logic                  input_hdr_ready,
    input  logic [DEST_WIDTH-1:0] input_hdr_dest,

    input  logic [DATA_WIDTH-1:0] input_payload_tdata,
    input  logic [KEEP_WIDTH-1:0] input_payload_tkeep,
    input  logic                  input_payload_tvalid,
    output logic                  input_payload_tready,
    input  logic                  input_payload_tlast,
    input  logic                  input_payload_tuser,

    output logic                  output_fd_valid,
    input  logic                  output_fd_ready,
    output logic [DEST_WIDTH-1:0] output_fd_dest,
    output logic [31:0]           output_fd_len,
    output logic                  output_fd_error,

    output logic                  busy,
    input  logic                  clear_stats,
    output logic [31:0]           frame_count,
    output logic [31:0]           byte_count,
    output logic [31:0]           error_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FRAME  = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  hdr_ready_q;
    logic                  tready_q;
    logic                  fd_valid_q;
    logic                  busy_q;
    logic [DEST_WIDTH-1:0] dest_q;
    logic [31:0]           len_q;
    logic                  err_q;
    logic [31:0]           frame_count_q;
    logic [31:0]           byte_count_q;
    logic [31:0]           error_count_q;

    logic                  hdr_hs_s;
    logic                  beat_hs_s;
    logic                  last_hs_s;
    logic                  fd_hs_s;
    logic [31:0]           beat_bytes_s;
    logic                  beat_err_s;
    logic [32:0]           len_sum_s;
    logic [31:0]           len_next_s;
    logic [31:0]           frame_inc_s;
    logic [31:0]           byte_inc_s;
    logic [31:0]           error_inc_s;

    // Payload contents are never inspected; only framing and byte enables matter.
    logic unused_tdata_s;
    assign unused_tdata_s = ^input_payload_tdata;

    function automatic logic [31:0] keep_popcount(input logic [KEEP_WIDTH-1:0] keep);
        logic [31:0] cnt;
        cnt = 32'd0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            cnt = cnt + {31'd0, keep[i]};
        end
        return cnt;
    endfunction

    // A legal final beat has contiguous low-order byte enables (including none).
    function automatic logic keep_is_low_mask(input logic [KEEP_WIDTH-1:0] keep);
        logic [KEEP_WIDTH-1:0] plus_one;
        plus_one = keep + {{(KEEP_WIDTH-1){1'b0}}, 1'b1};
        return ((keep & plus_one) == {KEEP_WIDTH{1'b0}});
    endfunction

    assign hdr_hs_s  = (state_q == ST_IDLE)   && input_hdr_valid      && hdr_ready_q;
    assign beat_hs_s = (state_q == ST_FRAME)  && input_payload_tvalid && tready_q;
    assign last_hs_s = beat_hs_s && input_payload_tlast;
    assign fd_hs_s   = (state_q == ST_REPORT) && fd_valid_q           && output_fd_ready;

    // Next-state selection for the frame FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (hdr_hs_s) state_d = ST_FRAME;
                else          state_d = ST_IDLE;
            end
            ST_FRAME: begin
                if (last_hs_s) state_d = ST_REPORT;
                else           state_d = ST_FRAME;
            end
            ST_REPORT: begin
                if (fd_hs_s) state_d = ST_IDLE;
                else         state_d = ST_REPORT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Per-beat byte count, error detection and saturating length update.
    always_comb begin
        beat_bytes_s = keep_popcount(input_payload_tkeep);
        beat_err_s   = input_payload_tuser;
        if (input_payload_tlast) begin
            if (!keep_is_low_mask(input_payload_tkeep)) beat_err_s = 1'b1;
            else                                        beat_err_s = input_payload_tuser;
        end else begin
            if (input_payload_tkeep != {KEEP_WIDTH{1'b1}}) beat_err_s = 1'b1;
            else                                           beat_err_s = input_payload_tuser;
        end
        len_sum_s = {1'b0, len_q} + {1'b0, beat_bytes_s};
        if (len_sum_s[32]) len_next_s = 32'hFFFF_FFFF;
        else               len_next_s = len_sum_s[31:0];
        frame_inc_s = {31'd0, last_hs_s};
        error_inc_s = {31'd0, last_hs_s & (err_q | beat_err_s)};
        if (beat_hs_s) byte_inc_s = beat_bytes_s;
        else           byte_inc_s = 32'd0;
    end

    // Frame FSM with registered handshake outputs and descriptor fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hdr_ready_q <= 1'b0;
            tready_q    <= 1'b0;
            fd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            dest_q      <= {DEST_WIDTH{1'b0}};
            len_q       <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_ready_q <= (state_d == ST_IDLE);
            tready_q    <= (state_d == ST_FRAME);
            fd_valid_q  <= (state_d == ST_REPORT);
            busy_q      <= (state_d != ST_IDLE);
            if (hdr_hs_s) begin
                dest_q <= input_hdr_dest;
                len_q  <= 32'd0;
                err_q  <= 1'b0;
            end else if (beat_hs_s) begin
                len_q <= len_next_s;
                err_q <= err_q | beat_err_s;
            end else begin
                len_q <= len_q;
                err_q <= err_q;
            end
        end
    end

    // Statistics; a clear in the same cycle as an increment keeps the increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count_q <= 32'd0;
            byte_count_q  <= 32'd0;
            error_count_q <= 32'd0;
        end else if (clear_stats) begin
            frame_count_q <= frame_inc_s;
            byte_count_q  <= byte_inc_s;
            error_count_q <= error_inc_s;
        end else begin
            frame_count_q <= frame_count_q + frame_inc_s;
            byte_count_q  <= byte_count_q + byte_inc_s;
            error_count_q <= error_count_q + error_inc_s;
        end
    end

    assign input_hdr_ready      = hdr_ready_q;
    assign input_payload_tready = tready_q;
    assign output_fd_valid      = fd_valid_q;
    assign output_fd_dest       = dest_q;
    assign output_fd_len        = len_q;
    assign output_fd_error      = err_q;
    assign busy                 = busy_q;
    assign frame_count          = frame_count_q;
    assign byte_count           = byte_count_q;
    assign error_count          = error_count_q;

endmodule
